// File: rtl/fx_cmd_pkg.sv
// rtl/fx_cmd_pkg.sv - shared constants and state encoding for the fx command master
// FX_WR_ACK_EN adds the write-acknowledge state.
package fx_cmd_pkg;

   localparam logic [7:0] FX_SYNC   = 8'hA5;
   localparam logic [7:0] FX_CMD_WR = 8'h57;
   localparam logic [7:0] FX_CMD_RD = 8'h52;
   localparam logic [7:0] FX_ACK    = 8'h4B;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_AH,
      ST_AL,
      ST_DAT,
      ST_WR,
      ST_RD,
      ST_RWAIT,
`ifdef FX_WR_ACK_EN
      ST_TX,
      ST_ACK
`else
      ST_TX
`endif
   } fx_state_e;

endpackage

// File: rtl/fx_cmd_tmr.sv
// rtl/fx_cmd_tmr.sv - inter-byte timeout counter for the fx command parser
module fx_cmd_tmr #(
   parameter logic [15:0] TO_CYC = 16'd50000
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [15:0] cnt_q, cnt_d;

   // Held at zero whenever disabled, so every frame starts from a clean count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = 16'd0;
      end else if (cnt_q != TO_CYC - 16'd1) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en && (cnt_q == TO_CYC - 16'd1);

endmodule

// File: rtl/fx_cmd_master.sv
// rtl/fx_cmd_master.sv - host byte-stream frame parser and fx bus master
// FX_WR_ACK_EN: when defined, each write is acknowledged with FX_ACK on tx.
module fx_cmd_master
   import fx_cmd_pkg::*;
#(
   parameter logic [15:0] TO_CYC = 16'd50000
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        rx_vld,
   input  logic [7:0]  rx_data,
   output logic        tx_vld,
   output logic [7:0]  tx_data,
   input  logic        tx_rdy,
   output logic [15:0] fx_waddr,
   output logic        fx_wr,
   output logic [7:0]  fx_data,
   output logic [15:0] fx_raddr,
   output logic        fx_rd,
   input  logic [7:0]  fx_q,
   output logic [7:0]  err_cnt
);

   fx_state_e   state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [7:0]  ah_q, ah_d;
   logic [7:0]  al_q, al_d;
   logic [15:0] waddr_q, waddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [15:0] raddr_q, raddr_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic        txv_q, txv_d;
   logic [7:0]  txd_q, txd_d;
   logic [7:0]  err_q, err_d;
   logic        err_inc;
   logic        tmr_en;
   logic        tmr_exp;

   fx_cmd_tmr #(.TO_CYC(TO_CYC)) u_tmr (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .clr     (rx_vld),
      .en      (tmr_en),
      .expire  (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      ah_d    = ah_q;
      al_d    = al_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      txv_d   = txv_q;
      txd_d   = txd_q;
      err_inc = 1'b0;
      tmr_en  = (state_q == ST_CMD) || (state_q == ST_AH) ||
                (state_q == ST_AL)  || (state_q == ST_DAT);

      // A received byte takes priority over a timeout landing in the same cycle.
      case (state_q)
         ST_IDLE: begin
            if (rx_vld && rx_data == FX_SYNC) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (rx_vld) begin
               if (rx_data == FX_CMD_WR) begin
                  is_wr_d = 1'b1;
                  state_d = ST_AH;
               end else if (rx_data == FX_CMD_RD) begin
                  is_wr_d = 1'b0;
                  state_d = ST_AH;
               end else begin
                  err_inc = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (tmr_exp) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_AH: begin
            if (rx_vld) begin
               ah_d    = rx_data;
               state_d = ST_AL;
            end else if (tmr_exp) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_AL: begin
            if (rx_vld) begin
               if (is_wr_q) begin
                  al_d    = rx_data;
                  state_d = ST_DAT;
               end else begin
                  raddr_d = {ah_q, rx_data};
                  rd_d    = 1'b1;
                  state_d = ST_RD;
               end
            end else if (tmr_exp) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DAT: begin
            if (rx_vld) begin
               waddr_d = {ah_q, al_q};
               wdata_d = rx_data;
               wr_d    = 1'b1;
               state_d = ST_WR;
            end else if (tmr_exp) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WR: begin
`ifdef FX_WR_ACK_EN
            txv_d   = 1'b1;
            txd_d   = FX_ACK;
            state_d = ST_ACK;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_RD: begin
            state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            txd_d   = fx_q;
            txv_d   = 1'b1;
            state_d = ST_TX;
         end
`ifdef FX_WR_ACK_EN
         ST_TX, ST_ACK: begin
`else
         ST_TX: begin
`endif
            if (tx_rdy) begin
               txv_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         is_wr_q <= 1'b0;
         ah_q    <= 8'd0;
         al_q    <= 8'd0;
         waddr_q <= 16'd0;
         wdata_q <= 8'd0;
         raddr_q <= 16'd0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         txv_q   <= 1'b0;
         txd_q   <= 8'd0;
         err_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         ah_q    <= ah_d;
         al_q    <= al_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         txv_q   <= txv_d;
         txd_q   <= txd_d;
         err_q   <= err_d;
      end
   end

   assign tx_vld   = txv_q;
   assign tx_data  = txd_q;
   assign fx_waddr = waddr_q;
   assign fx_wr    = wr_q;
   assign fx_data  = wdata_q;
   assign fx_raddr = raddr_q;
   assign fx_rd    = rd_q;
   assign err_cnt  = err_q;

endmodule

// File: tb/tb_fx_cmd_master.sv
// tb/tb_fx_cmd_master.sv - self-checking bench for fx_cmd_master (honours FX_WR_ACK_EN)
module tb_fx_cmd_master;

   localparam logic [15:0] TO = 16'd16;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic        rx_vld  = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        tx_rdy  = 1'b0;
   logic [7:0]  fx_q    = 8'd0;
   logic        tx_vld;
   logic [7:0]  tx_data;
   logic [15:0] fx_waddr;
   logic        fx_wr;
   logic [7:0]  fx_data;
   logic [15:0] fx_raddr;
   logic        fx_rd;
   logic [7:0]  err_cnt;

   fx_cmd_master #(.TO_CYC(TO)) dut (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .rx_vld   (rx_vld),
      .rx_data  (rx_data),
      .tx_vld   (tx_vld),
      .tx_data  (tx_data),
      .tx_rdy   (tx_rdy),
      .fx_waddr (fx_waddr),
      .fx_wr    (fx_wr),
      .fx_data  (fx_data),
      .fx_raddr (fx_raddr),
      .fx_rd    (fx_rd),
      .fx_q     (fx_q),
      .err_cnt  (err_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Slave register file: answers one cycle after fx_rd, zero otherwise.
   logic [7:0] mem [0:255];
   initial begin
      logic        rd_prev;
      logic [15:0] ra_prev;
      rd_prev = 1'b0;
      ra_prev = 16'd0;
      forever begin
         @(posedge clk_sys);
         #1;
         fx_q    = rd_prev ? mem[ra_prev[7:0]] : 8'h00;
         rd_prev = fx_rd;
         ra_prev = fx_raddr;
      end
   end

   // 0 random, 1 held low, 2 held high
   int rdy_mode = 2;
   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         if (rdy_mode == 0) tx_rdy = ($urandom_range(0, 9) < 6);
         else               tx_rdy = (rdy_mode == 2);
      end
   end

   // Reference model: counts frame bytes and post-frame latencies.
   logic        e_txv, e_wr, e_rd;
   logic [7:0]  e_txd, e_data, e_err;
   logic [15:0] e_waddr, e_raddr;
   int          nb, gap, rd_pend;
   bit          wr_pend, wait_tx, m_is_wr;
   logic [7:0]  m_ah, m_al;

   task automatic model_reset();
      e_txv = 0; e_wr = 0; e_rd = 0; e_txd = 0; e_data = 0; e_err = 0;
      e_waddr = 0; e_raddr = 0;
      nb = 0; gap = 0; rd_pend = 0; wr_pend = 0; wait_tx = 0; m_is_wr = 0;
      m_ah = 0; m_al = 0;
   endtask

   task automatic bump_err();
      if (e_err != 8'hFF) e_err = e_err + 8'd1;
   endtask

   task automatic model_step();
      e_wr = 0;
      e_rd = 0;
      if (wait_tx) begin
         if (tx_rdy) begin e_txv = 0; wait_tx = 0; end
      end else if (rd_pend > 0) begin
         rd_pend--;
         if (rd_pend == 0) begin e_txd = mem[e_raddr[7:0]]; e_txv = 1; wait_tx = 1; end
      end else if (wr_pend) begin
         wr_pend = 0;
`ifdef FX_WR_ACK_EN
         e_txd = 8'h4B; e_txv = 1; wait_tx = 1;
`endif
      end else if (rx_vld) begin
         gap = 0;
         case (nb)
            0: if (rx_data == 8'hA5) nb = 1;
            1: begin
               if (rx_data == 8'h57)      begin m_is_wr = 1; nb = 2; end
               else if (rx_data == 8'h52) begin m_is_wr = 0; nb = 2; end
               else begin nb = 0; bump_err(); end
            end
            2: begin m_ah = rx_data; nb = 3; end
            3: begin
               if (m_is_wr) begin m_al = rx_data; nb = 4; end
               else begin e_raddr = {m_ah, rx_data}; e_rd = 1; rd_pend = 2; nb = 0; end
            end
            default: begin
               e_waddr = {m_ah, m_al}; e_data = rx_data; e_wr = 1; wr_pend = 1; nb = 0;
            end
         endcase
      end else if (nb > 0) begin
         gap++;
         if (gap >= int'(TO)) begin nb = 0; bump_err(); end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_sys or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Per-cycle compare plus event bookkeeping for the directed checks.
   int         cyc = 0, wr_cnt = 0, rd_cnt = 0, hs_cnt = 0, rd_cyc = 0, rise_cyc = 0;
   logic [7:0] hs_data = 8'd0;
   logic       txv_prev = 1'b0;
   initial begin
      forever begin
         @(negedge clk_sys);
         cyc++;
         chk("tx_vld",   {31'd0, tx_vld}, {31'd0, e_txv});
         chk("tx_data",  {24'd0, tx_data}, {24'd0, e_txd});
         chk("fx_wr",    {31'd0, fx_wr}, {31'd0, e_wr});
         chk("fx_rd",    {31'd0, fx_rd}, {31'd0, e_rd});
         chk("fx_waddr", {16'd0, fx_waddr}, {16'd0, e_waddr});
         chk("fx_raddr", {16'd0, fx_raddr}, {16'd0, e_raddr});
         chk("fx_data",  {24'd0, fx_data}, {24'd0, e_data});
         chk("err_cnt",  {24'd0, err_cnt}, {24'd0, e_err});
         if (fx_wr) wr_cnt++;
         if (fx_rd) begin rd_cnt++; rd_cyc = cyc; end
         if (tx_vld && !txv_prev) rise_cyc = cyc;
         txv_prev = tx_vld;
         if (tx_vld && tx_rdy) begin hs_cnt++; hs_data = tx_data; end
      end
   end

   task automatic send(input logic [7:0] b, input int g);
      rx_vld  = 1'b1;
      rx_data = b;
      @(posedge clk_sys); #1;
      rx_vld = 1'b0;
      repeat (g) begin @(posedge clk_sys); #1; end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk_sys); #1; end
   endtask

   task automatic send_rd(input logic [7:0] ah, input logic [7:0] al);
      send(8'hA5, 0); send(8'h52, 0); send(ah, 0); send(al, 0);
   endtask

   task automatic send_wr(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d);
      send(8'hA5, 0); send(8'h57, 0); send(ah, 0); send(al, 0); send(d, 0);
   endtask

   int w0, r0, h0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h80] = 8'h3C;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      chk("reset_err_cnt", {24'd0, err_cnt}, 32'h0);
      chk("reset_tx_vld", {31'd0, tx_vld}, 32'h0);
      chk("reset_fx_waddr", {16'd0, fx_waddr}, 32'h0);

      // write
      w0 = wr_cnt; h0 = hs_cnt;
      send_wr(8'h02, 8'h80, 8'h3C);
      idle(6);
      chk("write_pulses", w0 + 1, wr_cnt);
      chk("write_addr", {16'd0, fx_waddr}, 32'h0280);
      chk("write_data", {24'd0, fx_data}, 32'h3C);
`ifdef FX_WR_ACK_EN
      chk("write_ack_hs", hs_cnt - h0, 1);
      chk("write_ack_byte", {24'd0, hs_data}, 32'h4B);
`else
      chk("write_no_tx", hs_cnt - h0, 0);
`endif

      // read
      r0 = rd_cnt; h0 = hs_cnt;
      send_rd(8'h02, 8'h80);
      idle(6);
      chk("read_pulses", rd_cnt - r0, 1);
      chk("read_hs", hs_cnt - h0, 1);
      chk("read_data", {24'd0, hs_data}, 32'h3C);
      chk("read_latency", rise_cyc - rd_cyc, 2);

      // backpressure with extra bytes while busy
      rdy_mode = 1;
      r0 = rd_cnt; h0 = hs_cnt;
      send_rd(8'h02, 8'h80);
      send(8'hA5, 0); send(8'h52, 0); send(8'h02, 0); send(8'h80, 0); send(8'h11, 0);
      idle(8);
      chk("bp_no_hs_yet", hs_cnt - h0, 0);
      chk("bp_tx_held", {31'd0, tx_vld}, 32'h1);
      rdy_mode = 2;
      idle(5);
      chk("bp_one_hs", hs_cnt - h0, 1);
      chk("bp_data", {24'd0, hs_data}, 32'h3C);
      chk("bp_one_rd", rd_cnt - r0, 1);

      // bad command then a good read
      send(8'hA5, 0); send(8'h33, 0);
      idle(2);
      chk("badcmd_err", {24'd0, err_cnt}, 32'h1);
      h0 = hs_cnt;
      send_rd(8'h02, 8'h80);
      idle(6);
      chk("badcmd_next_read", hs_cnt - h0, 1);

      // timeout mid-frame
      r0 = rd_cnt;
      send(8'hA5, 0); send(8'h52, 0); send(8'h02, 0);
      idle(20);
      chk("timeout_err", {24'd0, err_cnt}, 32'h2);
      chk("timeout_no_rd", rd_cnt - r0, 0);
      w0 = wr_cnt;
      send_wr(8'h01, 8'h10, 8'h55);
      idle(6);
      chk("after_to_wr", wr_cnt - w0, 1);
      chk("after_to_waddr", {16'd0, fx_waddr}, 32'h0110);
      chk("raddr_kept", {16'd0, fx_raddr}, 32'h0280);

      // reset mid-frame
      send(8'hA5, 0); send(8'h57, 0); send(8'h02, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_err", {24'd0, err_cnt}, 32'h0);
      chk("rst_waddr", {16'd0, fx_waddr}, 32'h0);
      chk("rst_raddr", {16'd0, fx_raddr}, 32'h0);
      chk("rst_data", {24'd0, fx_data}, 32'h0);
      chk("rst_txd", {24'd0, tx_data}, 32'h0);
      @(posedge clk_sys); #1;
      rst_n = 1'b1;
      h0 = hs_cnt;
      send_rd(8'h03, 8'h80);
      idle(6);
      chk("post_rst_hs", hs_cnt - h0, 1);
      chk("post_rst_data", {24'd0, hs_data}, 32'h3C);
      chk("post_rst_raddr", {16'd0, fx_raddr}, 32'h0380);

      // randomized traffic
      rdy_mode = 0;
      for (int it = 0; it < 250; it++) begin
         int kind;
         kind = $urandom_range(0, 5);
         case (kind)
            0: begin
               send(8'hA5, $urandom_range(0, 3)); send(8'h57, $urandom_range(0, 3));
               send(8'($urandom), $urandom_range(0, 3)); send(8'($urandom), $urandom_range(0, 3));
               send(8'($urandom), 0);
            end
            1: begin
               send(8'hA5, $urandom_range(0, 3)); send(8'h52, $urandom_range(0, 3));
               send(8'($urandom), $urandom_range(0, 3)); send(8'($urandom), 0);
            end
            2: begin
               logic [7:0] c;
               c = 8'($urandom);
               if (c == 8'h57 || c == 8'h52) c = 8'h00;
               send(8'hA5, $urandom_range(0, 3)); send(c, 0);
            end
            3: send(8'($urandom), 0);
            4: begin
               send(8'hA5, 0);
               for (int k = 0; k < $urandom_range(0, 2); k++) send(8'h57, $urandom_range(0, 3));
               idle(20);
            end
            default: begin
               send(8'hA5, 0); send(8'h57, 0); send(8'hA5, 1); send(8'hA5, 0); send(8'hA5, 0);
            end
         endcase
         idle($urandom_range(0, 6));
      end
      rdy_mode = 2;
      idle(10);

      // err_cnt saturation
      for (int i = 0; i < 260; i++) begin
         send(8'hA5, 0); send(8'h33, 0);
      end
      idle(2);
      chk("err_saturated", {24'd0, err_cnt}, 32'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
